// File: rtl/rule110_pkg.sv
// Shared types and constants for the rule110 sequencer and its bench.
package rule110_pkg;

    localparam int WIDTH  = 256;
    localparam int WORD   = 16;
    localparam int NWORDS = WIDTH / WORD;

    // Wolfram rule number: bit {left,centre,right} of RULE is the next cell.
    localparam logic [7:0] RULE = 8'd110;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        EMIT,
        STEP,
        DONE
    } state_t;

    // Reference next generation; cells beyond either end read as 0.
    function automatic logic [WIDTH-1:0] rule110_next(input logic [WIDTH-1:0] cur);
        logic [WIDTH+1:0] pad;
        logic [WIDTH-1:0] nxt;
        pad = {1'b0, cur, 1'b0};
        nxt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            nxt[i] = RULE[pad[i+2 -: 3]];
        end
        return nxt;
    endfunction

endpackage

// File: rtl/rule110_cell_buf.sv
// Cell register with a word write port, full-width parallel load and word read mux.
// Word k occupies cells[WIDTH-1-WORD*k -: WORD] (word 0 is the MSB word).
module rule110_cell_buf #(
    parameter int WIDTH = 256,
    parameter int WORD  = 16,
    parameter int IDX_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic [WORD-1:0]  i_wr_data,
    input  logic             i_ld_en,
    input  logic [WIDTH-1:0] i_ld_data,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic [WORD-1:0]  o_rd_data,
    output logic [WIDTH-1:0] o_cells
);

    localparam int NW = WIDTH / WORD;

    logic [WIDTH-1:0] r_cells;
    logic [WORD-1:0]  w_rd_data;

    // Parallel load from the datapath wins over a seed word write.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cells <= '0;
        end else if (i_ld_en) begin
            r_cells <= i_ld_data;
        end else if (i_wr_en) begin
            for (int k = 0; k < NW; k++) begin
                if (i_wr_idx == IDX_W'(k)) begin
                    r_cells[WIDTH-1-WORD*k -: WORD] <= i_wr_data;
                end
            end
        end
    end

    // Word read mux using the same word ordering as the write port.
    always_comb begin
        w_rd_data = '0;
        for (int k = 0; k < NW; k++) begin
            if (i_rd_idx == IDX_W'(k)) begin
                w_rd_data = r_cells[WIDTH-1-WORD*k -: WORD];
            end
        end
    end

    assign o_rd_data = w_rd_data;
    assign o_cells   = r_cells;

endmodule

// File: rtl/rule110_seq_ctrl.sv
// Sequencer for the rule110 datapath: loads a seed, steps the datapath
// gen_count times and streams every generation as WORD-bit words.
module rule110_seq_ctrl #(
    parameter int WIDTH = 256,
    parameter int WORD  = 16,
    parameter int GEN_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [GEN_W-1:0] i_gen_count,
    input  logic             i_abort,
    input  logic             i_seed_valid,
    output logic             o_seed_ready,
    input  logic [WORD-1:0]  i_seed_data,
    output logic [WIDTH-1:0] o_dp_in,
    output logic             o_dp_ena,
    input  logic [WIDTH-1:0] i_dp_out,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WORD-1:0]  o_out_data,
    output logic             o_out_last,
    output logic [GEN_W-1:0] o_out_gen,
    output logic             o_busy,
    output logic             o_done
);

    import rule110_pkg::state_t;
    import rule110_pkg::IDLE;
    import rule110_pkg::LOAD;
    import rule110_pkg::EMIT;
    import rule110_pkg::STEP;
    import rule110_pkg::DONE;

    localparam int NW    = WIDTH / WORD;
    localparam int IDX_W = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NW - 1);

    state_t           r_state;
    logic [GEN_W-1:0] r_gcnt;
    logic [GEN_W-1:0] r_gen;
    logic [IDX_W-1:0] r_widx;
    logic             r_seed_ready;
    logic             r_out_valid;
    logic             r_dp_ena;
    logic             r_busy;
    logic             r_done;

    logic             w_abort;
    logic             w_seed_hs;
    logic             w_out_hs;
    logic             w_last;
    logic             w_ld;
    logic [WORD-1:0]  w_rd_data;
    logic [WIDTH-1:0] w_cells;

    // Abort only counts outside IDLE and suppresses any handshake in its cycle.
    assign w_abort   = i_abort && (r_state != IDLE);
    assign w_seed_hs = r_seed_ready && i_seed_valid && !w_abort;
    assign w_out_hs  = r_out_valid && i_out_ready && !w_abort;
    assign w_last    = (r_widx == LAST_IDX);
    assign w_ld      = r_dp_ena && !w_abort;

    rule110_cell_buf #(
        .WIDTH (WIDTH),
        .WORD  (WORD),
        .IDX_W (IDX_W)
    ) u_cells (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_wr_en   (w_seed_hs),
        .i_wr_idx  (r_widx),
        .i_wr_data (i_seed_data),
        .i_ld_en   (w_ld),
        .i_ld_data (i_dp_out),
        .i_rd_idx  (r_widx),
        .o_rd_data (w_rd_data),
        .o_cells   (w_cells)
    );

    // Control FSM: state, counters and all handshake/status flags.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_gcnt       <= '0;
            r_gen        <= '0;
            r_widx       <= '0;
            r_seed_ready <= 1'b0;
            r_out_valid  <= 1'b0;
            r_dp_ena     <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else if (w_abort) begin
            r_state      <= IDLE;
            r_seed_ready <= 1'b0;
            r_out_valid  <= 1'b0;
            r_dp_ena     <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_state      <= LOAD;
                        r_gcnt       <= i_gen_count;
                        r_gen        <= '0;
                        r_widx       <= '0;
                        r_seed_ready <= 1'b1;
                        r_busy       <= 1'b1;
                    end
                end
                LOAD: begin
                    if (w_seed_hs) begin
                        if (w_last) begin
                            r_state      <= EMIT;
                            r_widx       <= '0;
                            r_seed_ready <= 1'b0;
                            r_out_valid  <= 1'b1;
                        end else begin
                            r_widx <= r_widx + IDX_W'(1);
                        end
                    end
                end
                EMIT: begin
                    if (w_out_hs) begin
                        if (w_last) begin
                            r_widx      <= '0;
                            r_out_valid <= 1'b0;
                            if (r_gen == r_gcnt) begin
                                r_state <= DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state  <= STEP;
                                r_dp_ena <= 1'b1;
                            end
                        end else begin
                            r_widx <= r_widx + IDX_W'(1);
                        end
                    end
                end
                STEP: begin
                    r_state     <= EMIT;
                    r_dp_ena    <= 1'b0;
                    r_gen       <= r_gen + GEN_W'(1);
                    r_widx      <= '0;
                    r_out_valid <= 1'b1;
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state      <= IDLE;
                    r_seed_ready <= 1'b0;
                    r_out_valid  <= 1'b0;
                    r_dp_ena     <= 1'b0;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

    assign o_seed_ready = r_seed_ready;
    assign o_dp_in      = w_cells;
    assign o_dp_ena     = r_dp_ena;
    assign o_out_valid  = r_out_valid;
    assign o_out_data   = w_rd_data;
    assign o_out_last   = r_out_valid && w_last;
    assign o_out_gen    = r_gen;
    assign o_busy       = r_busy;
    assign o_done       = r_done;

endmodule
